// File: rtl/serial_chunk_adder_pkg.sv
// Shared state encoding and sizing helpers for the serial chunk adder.
// Sizing helpers are constant functions so they can feed localparams.
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sca_state_t;

    function automatic int sca_n_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter must stay at least one bit wide even when a single chunk covers the word.
    function automatic int sca_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk.sv
// CHUNK-bit ripple chain of full adders; purely combinational.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    always_comb begin
        logic w_c;
        w_c      = ci;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb_in = w_c;
            s[i] = x[i] ^ y[i] ^ w_c;
            w_c  = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
        end
        co = w_c;
    end

endmodule

// File: rtl/serial_chunk_adder.sv
// Serial add/subtract of WIDTH-bit operands, CHUNK bits per clock; done N+1 edges after accept.
// No backpressure: start is only taken while ready, results hold until the next done.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = sca_n_chunks(WIDTH, CHUNK);
    localparam int CW = sca_cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sca_state_t       r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_ovf_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_acc_next;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .x        (r_opa[CHUNK-1:0]),
        .y        (r_opb[CHUNK-1:0]),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_cmsb)
    );

    // Chunk sums enter from the MSB side so after N steps the LSB chunk sits at bit 0.
    generate
        if (N == 1) begin : g_single
            assign w_acc_next = w_s;
        end else begin : g_multi
            assign w_acc_next = {w_s, r_acc[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_opa     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_ovf_acc <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_opa   <= r_opa >> CHUNK;
                    r_opb   <= r_opb >> CHUNK;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_ovf_acc <= w_cmsb ^ w_co;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_sum   <= r_acc;
                    r_cout  <= r_carry;
                    r_ovf   <= r_ovf_acc;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready    = (r_state == ST_IDLE);
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder in three shapes: 8/4, 32/1 and 8/8.
// Results are checked against signed/unsigned integer arithmetic on the operands.
module tb_serial_chunk_adder;

    logic        clk;
    logic        rst_d [3];
    logic        st_d  [3];
    logic        sb_d  [3];
    logic [31:0] a_d   [3];
    logic [31:0] b_d   [3];

    logic        rdy_d [3];
    logic        dn_d  [3];
    logic [31:0] sum_d [3];
    logic        co_d  [3];
    logic        ov_d  [3];

    logic [7:0]  s0, s2;
    logic [31:0] s1;
    logic        rdy0, rdy1, rdy2, dn0, dn1, dn2, co0, co1, co2, ov0, ov1, ov2;

    int vectors = 0;
    int errors  = 0;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_dut0 (
        .clk(clk), .rst(rst_d[0]), .start(st_d[0]), .sub(sb_d[0]),
        .a(a_d[0][7:0]), .b(b_d[0][7:0]), .ready(rdy0), .done(dn0),
        .sum(s0), .cout(co0), .overflow(ov0)
    );

    serial_chunk_adder #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst_d[1]), .start(st_d[1]), .sub(sb_d[1]),
        .a(a_d[1]), .b(b_d[1]), .ready(rdy1), .done(dn1),
        .sum(s1), .cout(co1), .overflow(ov1)
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut2 (
        .clk(clk), .rst(rst_d[2]), .start(st_d[2]), .sub(sb_d[2]),
        .a(a_d[2][7:0]), .b(b_d[2][7:0]), .ready(rdy2), .done(dn2),
        .sum(s2), .cout(co2), .overflow(ov2)
    );

    always_comb begin
        rdy_d[0] = rdy0; rdy_d[1] = rdy1; rdy_d[2] = rdy2;
        dn_d[0]  = dn0;  dn_d[1]  = dn1;  dn_d[2]  = dn2;
        co_d[0]  = co0;  co_d[1]  = co1;  co_d[2]  = co2;
        ov_d[0]  = ov0;  ov_d[1]  = ov1;  ov_d[2]  = ov2;
        sum_d[0] = {24'd0, s0};
        sum_d[1] = s1;
        sum_d[2] = {24'd0, s2};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wof(input int d);
        return (d == 1) ? 32 : 8;
    endfunction

    function automatic int nof(input int d);
        case (d)
            0:       return 2;
            1:       return 32;
            default: return 1;
        endcase
    endfunction

    // {overflow, cout, sum} from integer arithmetic on the w-bit operands.
    function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                          input logic [31:0] bv, input logic sb);
        longint m, half, ua, ub, sa, sbv, r;
        logic [31:0] s;
        logic co, ov;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'({32'd0, av}) & (m - 1);
        ub   = longint'({32'd0, bv}) & (m - 1);
        sa   = (ua >= half) ? ua - m : ua;
        sbv  = (ub >= half) ? ub - m : ub;
        if (sb) begin
            r  = sa - sbv;
            co = (ua >= ub);
            s  = 32'((ua - ub) & (m - 1));
        end else begin
            r  = sa + sbv;
            co = ((ua + ub) >= m);
            s  = 32'((ua + ub) & (m - 1));
        end
        ov = (r < -half) || (r >= half);
        return {ov, co, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                         input logic sb, input bit hold);
        int k;
        int rdy_seen;
        logic [33:0] e;
        k = 0;
        while (!rdy_d[d] && k < 200) begin @(negedge clk); k++; end
        chk("ready_before_start", 64'(rdy_d[d]), 64'd1);
        a_d[d]  = av;
        b_d[d]  = bv;
        sb_d[d] = sb;
        st_d[d] = 1'b1;
        @(negedge clk);
        if (!hold) st_d[d] = 1'b0;
        k = 0;
        rdy_seen = 0;
        while (!dn_d[d] && k < 100) begin
            a_d[d]  = $urandom;
            b_d[d]  = $urandom;
            sb_d[d] = 1'($urandom_range(0, 1));
            if (rdy_d[d]) rdy_seen++;
            @(negedge clk);
            k++;
        end
        st_d[d] = 1'b0;
        e = model(wof(d), av, bv, sb);
        chk("done_latency", 64'(k), 64'(nof(d) + 1));
        chk("ready_low_while_busy", 64'(rdy_seen), 64'd0);
        chk("sum", 64'(sum_d[d]), 64'(e[31:0]));
        chk("cout", 64'(co_d[d]), 64'(e[32]));
        chk("overflow", 64'(ov_d[d]), 64'(e[33]));
        @(negedge clk);
        chk("done_one_cycle", 64'(dn_d[d]), 64'd0);
        chk("ready_after_done", 64'(rdy_d[d]), 64'd1);
        chk("sum_holds", 64'(sum_d[d]), 64'(e[31:0]));
    endtask

    initial begin
        int dn_seen;
        for (int d = 0; d < 3; d++) begin
            rst_d[d] = 1'b1; st_d[d] = 1'b0; sb_d[d] = 1'b0; a_d[d] = '0; b_d[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) rst_d[d] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", 64'(rdy_d[d]), 64'd1);
            chk("reset_done", 64'(dn_d[d]), 64'd0);
            chk("reset_sum", 64'(sum_d[d]), 64'd0);
            chk("reset_cout", 64'(co_d[d]), 64'd0);
            chk("reset_ovf", 64'(ov_d[d]), 64'd0);
        end

        // Directed corner cases.
        do_op(0, 32'h7F, 32'h01, 1'b0, 1'b0);
        do_op(0, 32'h05, 32'h07, 1'b1, 1'b0);
        do_op(0, 32'h07, 32'h05, 1'b1, 1'b0);
        do_op(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        do_op(2, 32'h80, 32'h80, 1'b0, 1'b0);
        do_op(0, 32'h00, 32'h80, 1'b1, 1'b0);
        do_op(1, 32'h80000000, 32'h00000001, 1'b1, 1'b0);

        // Start held across the whole operation while operands wander.
        do_op(0, 32'h3C, 32'h5A, 1'b0, 1'b1);
        do_op(1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);

        // Reset in the second RUN cycle aborts with no done pulse.
        a_d[0] = 32'h33; b_d[0] = 32'h44; sb_d[0] = 1'b0; st_d[0] = 1'b1;
        @(negedge clk);
        st_d[0] = 1'b0;
        @(negedge clk);
        rst_d[0] = 1'b1;
        @(negedge clk);
        rst_d[0] = 1'b0;
        chk("abort_ready", 64'(rdy_d[0]), 64'd1);
        chk("abort_sum", 64'(sum_d[0]), 64'd0);
        chk("abort_cout", 64'(co_d[0]), 64'd0);
        chk("abort_ovf", 64'(ov_d[0]), 64'd0);
        dn_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (dn_d[0]) dn_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(dn_seen), 64'd0);
        do_op(0, 32'h10, 32'h20, 1'b0, 1'b0);
        chk("after_abort_sum", 64'(sum_d[0]), 64'h30);

        // Reset and start together: request is dropped.
        rst_d[2] = 1'b1; st_d[2] = 1'b1; a_d[2] = 32'h11; b_d[2] = 32'h22;
        @(negedge clk);
        rst_d[2] = 1'b0; st_d[2] = 1'b0;
        chk("rst_start_ready", 64'(rdy_d[2]), 64'd1);
        dn_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dn_d[2]) dn_seen++;
        end
        chk("rst_start_no_done", 64'(dn_seen), 64'd0);
        chk("rst_start_sum", 64'(sum_d[2]), 64'd0);

        // Randomized operations on every shape.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 12; i++) begin
                do_op(d, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
